// File: rtl/ps2_receiver_if.sv
// Signal bundle between the PS/2 pins, the receiver and the downstream keyboard matrix.
// master: the receiver side. slave: the pin driver and scan-code consumer.
interface ps2_receiver_if;
    logic       ps2_clk;
    logic       ps2_dat;
    logic [7:0] scan_code;
    logic       scan_code_ready;
    logic       scan_code_error;
    logic       frame_busy;

    modport master (
        input  ps2_clk,
        input  ps2_dat,
        output scan_code,
        output scan_code_ready,
        output scan_code_error,
        output frame_busy
    );

    modport slave (
        output ps2_clk,
        output ps2_dat,
        input  scan_code,
        input  scan_code_ready,
        input  scan_code_error,
        input  frame_busy
    );
endinterface

// File: rtl/ps2_receiver.sv
// PS/2 device-to-host frame receiver: start, 8 data bits LSB first, odd parity, stop.
// Optional ps2_clk glitch filter enabled by defining PS2_RX_FILTER_EN.
module ps2_receiver #(
    parameter int unsigned TIMEOUT_CYCLES = 20000,
    parameter int unsigned FILTER_LEN     = 8
) (
    input logic            clk,
    input logic            reset,
    ps2_receiver_if.master bus
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

    logic [1:0] clk_sync_q;
    logic [1:0] dat_sync_q;
    logic       clk_lvl;
    logic       dat_smp;
    logic       clk_prev_q;
    logic       fall;

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
        end else begin
            clk_sync_q <= {clk_sync_q[0], bus.ps2_clk};
            dat_sync_q <= {dat_sync_q[0], bus.ps2_dat};
        end
    end

`ifdef PS2_RX_FILTER_EN
    localparam int unsigned FW = $clog2(FILTER_LEN);

    logic [FW-1:0]         filt_cnt_q;
    logic                  filt_lvl_q;
    logic [FILTER_LEN-1:0] dat_dly_q;

    // Data is delayed by the filter depth so it is still sampled mid-bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            filt_cnt_q <= '0;
            filt_lvl_q <= 1'b1;
            dat_dly_q  <= '1;
        end else begin
            dat_dly_q <= {dat_dly_q[FILTER_LEN-2:0], dat_sync_q[1]};
            if (clk_sync_q[1] == filt_lvl_q) begin
                filt_cnt_q <= '0;
            end else if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
                filt_lvl_q <= clk_sync_q[1];
                filt_cnt_q <= '0;
            end else begin
                filt_cnt_q <= filt_cnt_q + FW'(1);
            end
        end
    end

    assign clk_lvl = filt_lvl_q;
    assign dat_smp = dat_dly_q[FILTER_LEN-1];
`else
    logic unused_filter_len;

    assign unused_filter_len = ^FILTER_LEN;
    assign clk_lvl           = clk_sync_q[1];
    assign dat_smp           = dat_sync_q[1];
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_prev_q <= 1'b1;
        end else begin
            clk_prev_q <= clk_lvl;
        end
    end

    assign fall = clk_prev_q & ~clk_lvl;

    state_e        state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          parity_q, parity_d;
    logic [7:0]    code_q, code_d;
    logic          ready_q, ready_d;
    logic          error_q, error_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            code_q    <= 8'h00;
            ready_q   <= 1'b0;
            error_q   <= 1'b0;
            to_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            code_q    <= code_d;
            ready_q   <= ready_d;
            error_q   <= error_d;
            to_cnt_q  <= to_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        code_d    = code_q;
        ready_d   = 1'b0;
        error_d   = 1'b0;
        to_cnt_d  = to_cnt_q;

        if (fall) begin
            // A fall always beats a coincident timeout.
            to_cnt_d = '0;
            case (state_q)
                StIdle: begin
                    if (!dat_smp) begin
                        state_d   = StData;
                        bit_cnt_d = '0;
                    end
                end
                StData: begin
                    shift_d   = {dat_smp, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = StParity;
                    end
                end
                StParity: begin
                    parity_d = dat_smp;
                    state_d  = StStop;
                end
                StStop: begin
                    if (dat_smp && (^shift_q ^ parity_q)) begin
                        code_d  = shift_q;
                        ready_d = 1'b1;
                    end else begin
                        error_d = 1'b1;
                    end
                    state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end else if (state_q != StIdle) begin
            if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                error_d  = 1'b1;
                state_d  = StIdle;
                to_cnt_d = '0;
            end else begin
                to_cnt_d = to_cnt_q + TW'(1);
            end
        end else begin
            to_cnt_d = '0;
        end
    end

    assign bus.scan_code       = code_q;
    assign bus.scan_code_ready = ready_q;
    assign bus.scan_code_error = error_q;
    assign bus.frame_busy      = (state_q != StIdle);

endmodule

// File: tb/tb_ps2_receiver.sv
// Self-checking bench for ps2_receiver: directed frames, timeout, mid-frame reset
// and randomised frames checked against a frame-level model of the PS/2 rules.
module tb_ps2_receiver;

    localparam int unsigned TO   = 300;
    localparam int unsigned FL   = 4;
    localparam int          HALF = 25;
`ifdef PS2_RX_FILTER_EN
    localparam int          LAT  = 3 + FL;
`else
    localparam int          LAT  = 3;
`endif

    logic clk = 1'b0;
    logic reset;

    ps2_receiver_if ps2 ();

    ps2_receiver #(
        .TIMEOUT_CYCLES(TO),
        .FILTER_LEN    (FL)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (ps2)
    );

    always #5 clk = ~clk;

    int         checks    = 0;
    int         failures  = 0;
    int         cyc       = 0;
    int         ready_cnt = 0;
    int         error_cnt = 0;
    int         both_cnt  = 0;
    int         err_cyc   = 0;
    int         last_fall_cyc = 0;
    logic [7:0] exp_code  = 8'h00;
    logic [7:0] got_codes[$];

    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (ps2.scan_code_ready) begin
                ready_cnt++;
                got_codes.push_back(ps2.scan_code);
            end
            if (ps2.scan_code_error) begin
                error_cnt++;
                err_cyc = cyc;
            end
            if (ps2.scan_code_ready && ps2.scan_code_error) both_cnt++;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic odd_parity(input logic [7:0] d);
        return ($countones(d) % 2 == 0) ? 1'b1 : 1'b0;
    endfunction

    function automatic logic [10:0] build(input logic [7:0] d, input logic p, input logic stop);
        return {stop, p, d, 1'b0};
    endfunction

    // Device changes data while clock is high; a 3-clk low pulse can precede bit glitch_at.
    task automatic send_bits(input int n, input logic [10:0] bits, input int glitch_at);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ps2.ps2_dat = bits[i];
            if (i == glitch_at) begin
                wait_clks(8);
                ps2.ps2_clk = 1'b0;
                wait_clks(3);
                ps2.ps2_clk = 1'b1;
                wait_clks(HALF - 11);
            end else begin
                wait_clks(HALF);
            end
            ps2.ps2_clk   = 1'b0;
            last_fall_cyc = cyc;
            wait_clks(HALF);
            ps2.ps2_clk = 1'b1;
        end
    endtask

    task automatic run_frame(input string tag, input logic [7:0] d, input logic p,
                             input logic stop, input int glitch_at);
        int  r0;
        int  e0;
        logic good;
        good = stop && ((($countones(d) + int'(p)) % 2) == 1);
        r0 = ready_cnt;
        e0 = error_cnt;
        got_codes.delete();
        send_bits(11, build(d, p, stop), glitch_at);
        wait_clks(5);
        if (good) exp_code = d;
        chk({tag, "_ready"}, ready_cnt - r0, good ? 1 : 0);
        chk({tag, "_error"}, error_cnt - e0, good ? 0 : 1);
        chk({tag, "_code"}, ps2.scan_code, exp_code);
        chk({tag, "_busy"}, ps2.frame_busy, 0);
        if (good && got_codes.size() > 0) chk({tag, "_pulse_code"}, got_codes[0], d);
    endtask

    initial begin
        int          r0;
        int          e0;
        logic [7:0]  d;
        int          kind;
        logic        p;
        logic        stop;

        reset       = 1'b1;
        ps2.ps2_clk = 1'b1;
        ps2.ps2_dat = 1'b1;
        wait_clks(4);
        reset = 1'b0;
        wait_clks(2);
        chk("rst_code", ps2.scan_code, 8'h00);
        chk("rst_ready", ps2.scan_code_ready, 0);
        chk("rst_error", ps2.scan_code_error, 0);
        chk("rst_busy", ps2.frame_busy, 0);

        run_frame("f1c", 8'h1C, odd_parity(8'h1C), 1'b1, -1);
        run_frame("bb_f0", 8'hF0, odd_parity(8'hF0), 1'b1, -1);
        run_frame("bb_1c", 8'h1C, odd_parity(8'h1C), 1'b1, -1);
        run_frame("bad_par", 8'h5A, ~odd_parity(8'h5A), 1'b1, -1);
        run_frame("bad_stop", 8'h29, odd_parity(8'h29), 1'b0, -1);
        run_frame("good_29", 8'h29, odd_parity(8'h29), 1'b1, -1);

        // Stalled frame: 5 bits then clock held high.
        r0 = ready_cnt;
        e0 = error_cnt;
        send_bits(5, build(8'h33, odd_parity(8'h33), 1'b1), -1);
        chk("to_busy_mid", ps2.frame_busy, 1);
        wait_clks(TO + 20);
        chk("to_error", error_cnt - e0, 1);
        chk("to_latency", err_cyc - last_fall_cyc, TO + LAT);
        chk("to_ready", ready_cnt - r0, 0);
        chk("to_busy", ps2.frame_busy, 0);
        run_frame("after_to", 8'h4B, odd_parity(8'h4B), 1'b1, -1);

        // Reset mid-frame after start plus 4 data bits.
        r0 = ready_cnt;
        e0 = error_cnt;
        send_bits(5, build(8'hA5, odd_parity(8'hA5), 1'b1), -1);
        @(negedge clk);
        reset = 1'b1;
        wait_clks(2);
        reset    = 1'b0;
        exp_code = 8'h00;
        wait_clks(TO + 10);
        chk("rstmid_strobes", (ready_cnt - r0) + (error_cnt - e0), 0);
        chk("rstmid_busy", ps2.frame_busy, 0);
        chk("rstmid_code", ps2.scan_code, 8'h00);
        run_frame("f76", 8'h76, odd_parity(8'h76), 1'b1, -1);

`ifdef PS2_RX_FILTER_EN
        // Short low pulse with data low in idle must not start a frame.
        @(negedge clk);
        ps2.ps2_dat = 1'b0;
        wait_clks(4);
        ps2.ps2_clk = 1'b0;
        wait_clks(3);
        ps2.ps2_clk = 1'b1;
        wait_clks(10);
        chk("glitch_idle_busy", ps2.frame_busy, 0);
        ps2.ps2_dat = 1'b1;
        wait_clks(10);
        run_frame("glitch_data", 8'h3C, odd_parity(8'h3C), 1'b1, 4);
`endif

        for (int i = 0; i < 24; i++) begin
            d    = 8'($urandom_range(0, 255));
            kind = int'($urandom_range(0, 3));
            p    = (kind == 2) ? ~odd_parity(d) : odd_parity(d);
            stop = (kind == 3) ? 1'b0 : 1'b1;
            run_frame($sformatf("rnd%0d", i), d, p, stop, -1);
        end

        chk("ready_error_exclusive", both_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
